pipeline_hazard_ctrl: RTL and testbench

// Central stall/flush/forwarding controller for the 5-stage pipeline (ifidReg, idexReg, exmemReg, memwbReg).
// - Produces per-register write-enables and bubble-inserts for the pipeline registers, plus the PC write-enable.
// - Resolves load-use hazards, taken branches (resolved in MEM) and multi-cycle data-memory waits.
// - Runs a small FSM with a wait timeout, and saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with memory-wait timeout FSM and perf counters.
// Optional build macro PIPE_FORWARDING_EN: EX-stage forwarding with 1-cycle load-use stalls instead of full interlock.
module pipeline_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_access,
    input  logic             dmem_ready,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_rd,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             pc_src,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    // One spare code above WAIT_MAX so the wait counter can saturate when the timeout is off.
    localparam int WCW = $clog2(WAIT_MAX + 2);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt, wait_inc;
    logic           in_err, freeze, take, hazard, stall, timeout;
    logic [1:0]     fwd_a_c, fwd_b_c;

    function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] r);
        return we && (rd == r) && (rd != 5'd0);
    endfunction

`ifdef PIPE_FORWARDING_EN
    assign hazard  = ex_memread && (hit(ex_regwrite, ex_rd, id_rs) ||
                                    (id_uses_rt && hit(ex_regwrite, ex_rd, id_rt)));
    assign fwd_a_c = hit(mem_regwrite, mem_rd, ex_rs) ? 2'b10 :
                     hit(wb_regwrite,  wb_rd,  ex_rs) ? 2'b01 : 2'b00;
    assign fwd_b_c = hit(mem_regwrite, mem_rd, ex_rt) ? 2'b10 :
                     hit(wb_regwrite,  wb_rd,  ex_rt) ? 2'b01 : 2'b00;
`else
    // Full interlock: hold ID until every in-flight writer of its sources has retired.
    logic unused_fwd;
    assign unused_fwd = ^{ex_rs, ex_rt, ex_memread};
    assign hazard  = hit(ex_regwrite, ex_rd, id_rs) || hit(mem_regwrite, mem_rd, id_rs) ||
                     hit(wb_regwrite, wb_rd, id_rs) ||
                     (id_uses_rt && (hit(ex_regwrite, ex_rd, id_rt) ||
                                     hit(mem_regwrite, mem_rd, id_rt) ||
                                     hit(wb_regwrite, wb_rd, id_rt)));
    assign fwd_a_c = 2'b00;
    assign fwd_b_c = 2'b00;
`endif

    assign in_err   = (state == ERR);
    assign freeze   = ((state == RUN) && mem_access && !dmem_ready) ||
                      ((state == MEM_WAIT) && !dmem_ready);
    assign take     = !in_err && !freeze && mem_branch && mem_zero;
    assign stall    = !in_err && !freeze && !take && hazard;
    assign wait_inc = (&wait_cnt) ? wait_cnt : wait_cnt + WCW'(1);
    assign timeout  = (WAIT_MAX != 0) && (wait_inc >= WCW'(WAIT_MAX));

    always_comb begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_we     = 1'b0;
        exmem_we    = 1'b0;
        memwb_we    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_src      = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        if (rst_n && !in_err) begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            memwb_we = 1'b1;
            fwd_a    = fwd_a_c;
            fwd_b    = fwd_b_c;
            if (freeze) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_we     = 1'b0;
                exmem_we    = 1'b0;
                memwb_flush = 1'b1;
            end else if (take) begin
                pc_src      = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (stall) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: if (freeze) begin
                    wait_cnt <= wait_inc;
                    if (timeout) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: if (dmem_ready) begin
                    wait_cnt <= '0;
                    state    <= RUN;
                end else if (timeout) begin
                    wait_cnt <= wait_inc;
                    state    <= ERR;
                    mem_err  <= 1'b1;
                end else begin
                    wait_cnt <= wait_inc;
                end
                ERR:     state <= ERR;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (take && !(&flush_cnt))  flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=3 to reach saturation, WAIT_MAX=4 for the timeout).
module tb_pipeline_hazard_ctrl;
    logic       clk, rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic       id_uses_rt, ex_regwrite, ex_memread, mem_regwrite, mem_branch, mem_zero;
    logic       mem_access, dmem_ready, wb_regwrite;
    logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_src, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [2:0] stall_cnt, flush_cnt;
    int         checks = 0, fails = 0, exp_stall = 0;

    pipeline_hazard_ctrl #(.CNT_W(3), .WAIT_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0; mem_regwrite = 0; mem_rd = 0;
        mem_branch = 0; mem_zero = 0; mem_access = 0; dmem_ready = 0;
        wb_regwrite = 0; wb_rd = 0;
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic load_use();
        ex_regwrite = 1; ex_memread = 1; ex_rd = 2; id_rs = 2;
    endtask

    initial begin
        rst_n = 0;
        idle();
        mem_branch = 1; mem_zero = 1; mem_access = 1;
        #1;
        chk("rst_pc_we", 32'(pc_we), 0);
        chk("rst_memwb_we", 32'(memwb_we), 0);
        chk("rst_pc_src", 32'(pc_src), 0);
        chk("rst_memwb_flush", 32'(memwb_flush), 0);
        chk("rst_mem_err", 32'(mem_err), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);

        step(); rst_n = 1; #1;
        chk("normal_pc_we", 32'(pc_we), 1);
        chk("normal_idex_flush", 32'(idex_flush), 0);

        // Memory wait for 3 cycles, then reset while in MEM_WAIT
        for (int i = 0; i < 3; i++) begin
            step(); mem_access = 1; #1;
            chk("wait_pre_pc_we", 32'(pc_we), 0);
        end
        step(); mem_access = 1; #1;
        chk("midwait_frozen", 32'(memwb_flush), 1);
        rst_n = 0; #1;
        chk("midwait_rst_memwb_flush", 32'(memwb_flush), 0);
        chk("midwait_rst_pc_we", 32'(pc_we), 0);
        step(); rst_n = 1; #1;
        chk("post_rst_run_pc_we", 32'(pc_we), 1);

        // 3-cycle memory wait, release on cycle 4 (also proves wait counter was cleared)
        for (int i = 0; i < 3; i++) begin
            step(); mem_access = 1; #1;
            chk("wait_pc_we", 32'(pc_we), 0);
            chk("wait_exmem_we", 32'(exmem_we), 0);
            chk("wait_memwb_flush", 32'(memwb_flush), 1);
        end
        step(); mem_access = 1; dmem_ready = 1; #1;
        chk("wait_release_pc_we", 32'(pc_we), 1);
        chk("wait_release_memwb_flush", 32'(memwb_flush), 0);
        step(); #1;
        chk("after_wait_pc_we", 32'(pc_we), 1);
        chk("after_wait_mem_err", 32'(mem_err), 0);

`ifdef PIPE_FORWARDING_EN
        step(); load_use(); #1;
        chk("lu_pc_we", 32'(pc_we), 0);
        chk("lu_idex_flush", 32'(idex_flush), 1);
        chk("lu_exmem_we", 32'(exmem_we), 1);
        exp_stall++;
        step(); ex_rs = 2; wb_regwrite = 1; wb_rd = 2; #1;
        chk("lu_fwd_a", 32'(fwd_a), 32'h1);
        chk("lu_next_pc_we", 32'(pc_we), 1);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        step(); mem_regwrite = 1; mem_rd = 3; wb_regwrite = 1; wb_rd = 3; ex_rs = 3; #1;
        chk("fwd_mem_pri", 32'(fwd_a), 32'h2);
        chk("fwd_nostall", 32'(pc_we), 1);
        step(); mem_regwrite = 1; mem_rd = 0; ex_rs = 0; wb_regwrite = 1; wb_rd = 6; ex_rt = 6; #1;
        chk("fwd_r0", 32'(fwd_a), 32'h0);
        chk("fwd_b_wb", 32'(fwd_b), 32'h1);
        step(); ex_regwrite = 1; ex_rd = 2; id_rs = 2; #1;
        chk("alu_dep_nostall", 32'(pc_we), 1);
        step(); ex_regwrite = 1; ex_memread = 1; ex_rd = 5; id_rt = 5; #1;
        chk("rt_unused_nostall", 32'(pc_we), 1);
        id_uses_rt = 1; #1;
        chk("rt_used_stall", 32'(pc_we), 0);
        exp_stall++;
`else
        for (int i = 0; i < 3; i++) begin
            step(); id_rs = 4;
            if (i == 0) begin ex_regwrite = 1; ex_rd = 4; end
            if (i == 1) begin mem_regwrite = 1; mem_rd = 4; end
            if (i == 2) begin wb_regwrite = 1; wb_rd = 4; end
            #1;
            chk("il_pc_we", 32'(pc_we), 0);
            chk("il_ifid_we", 32'(ifid_we), 0);
            chk("il_idex_flush", 32'(idex_flush), 1);
            chk("il_memwb_we", 32'(memwb_we), 1);
            exp_stall++;
        end
        step(); id_rs = 4; #1;
        chk("il_release_pc_we", 32'(pc_we), 1);
        chk("il_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        step(); mem_regwrite = 1; mem_rd = 3; ex_rs = 3; #1;
        chk("nofwd_fwd_a", 32'(fwd_a), 32'h0);
        step(); ex_regwrite = 1; ex_rd = 0; id_rs = 0; #1;
        chk("r0_nostall", 32'(pc_we), 1);
        step(); ex_regwrite = 1; ex_rd = 5; id_rt = 5; #1;
        chk("rt_unused_nostall", 32'(pc_we), 1);
        id_uses_rt = 1; #1;
        chk("rt_used_stall", 32'(pc_we), 0);
        exp_stall++;
`endif

        // Taken branch with a simultaneous load-use hazard: flush wins
        step(); load_use(); mem_branch = 1; mem_zero = 1; #1;
        chk("br_pc_src", 32'(pc_src), 1);
        chk("br_pc_we", 32'(pc_we), 1);
        chk("br_flushes", 32'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 32'hE);
        chk("br_ifid_we", 32'(ifid_we), 1);
        step(); mem_branch = 1; mem_zero = 0; #1;
        chk("br_flush_cnt", 32'(flush_cnt), 1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        chk("br_not_taken", 32'(pc_src), 0);

        // Hold a hazard long enough to saturate the 3-bit stall counter
        for (int i = 0; i < 8; i++) begin
            step(); load_use();
        end
        step(); #1;
        chk("stall_sat", 32'(stall_cnt), 32'h7);

        // Timeout: 4 wait cycles with dmem_ready low -> ERR
        for (int i = 0; i < 4; i++) begin
            step(); mem_access = 1; #1;
            chk("to_pre_mem_err", 32'(mem_err), 0);
        end
        step(); mem_access = 1; #1;
        chk("to_mem_err", 32'(mem_err), 1);
        chk("to_pc_we", 32'(pc_we), 0);
        chk("to_memwb_we", 32'(memwb_we), 0);
        chk("to_memwb_flush", 32'(memwb_flush), 0);
        step(); dmem_ready = 1; mem_branch = 1; mem_zero = 1; #1;
        chk("err_sticky_pc_we", 32'(pc_we), 0);
        chk("err_sticky_pc_src", 32'(pc_src), 0);
        step(); #1;
        chk("err_sticky_mem_err", 32'(mem_err), 1);
        rst_n = 0; #1;
        chk("err_rst_mem_err", 32'(mem_err), 0);
        chk("err_rst_flush_cnt", 32'(flush_cnt), 0);
        step(); rst_n = 1; #1;
        chk("err_rst_run", 32'(pc_we), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
